riscv_if_prefetch: RTL and testbench
====================================

// Module: riscv_if_prefetch
// PURPOSE
//  Instruction prefetch buffer between the instruction memory bus and the core fetch port.
//  Takes fetch addresses from the core (if_nxt_pc), issues pipelined word reads, and queues returned parcels.
//  Presents each parcel, with its PC and fault flags, on the core's if_parcel* inputs.
//  Handles flushes by dropping queued and in-flight responses; reports misaligned PCs without a bus access.
// PARAMETERS
//  XLEN        32  address/data width
//  PARCEL_SIZE 32  parcel width; must equal XLEN
//  DEPTH       4   parcel queue entries; power of 2, >=2
//  MAX_OUTST   2   max outstanding bus reads, 1..DEPTH
// PORTS
//  clk                  in  1           clock; all state on rising edge
//  rst                  in  1           asynchronous, active-high reset
//  if_nxt_pc            in  XLEN        next fetch address from core
//  if_stall             in  1           core not consuming parcel this cycle
//  if_flush             in  1           discard everything; restart at if_nxt_pc
//  if_stall_nxt_pc      out 1           1 = if_nxt_pc not accepted this cycle
//  if_parcel            out PARCEL_SIZE queue-head instruction parcel
//  if_parcel_pc         out XLEN        PC of queue head
//  if_parcel_valid      out 1           queue head valid
//  if_parcel_misaligned out 1           head PC[1:0]!=0, no bus access made
//  if_parcel_page_fault out 1           bus returned error for head
//  imem_req             out 1           read request
//  imem_adr             out XLEN        read address (= if_nxt_pc when issued)
//  imem_stall           in  1           bus cannot accept request this cycle
//  imem_ack             in  1           read data valid; in order, >=1 cycle after acceptance
//  imem_q               in  XLEN        read data
//  imem_err             in  1           access fault, qualified by imem_ack
// BEHAVIOUR
//  Reset:
//  - Queue empty; outst=0; discard=0.
//  - if_parcel_valid=0, if_stall_nxt_pc=1, imem_req=0; all data outputs 0.
//  Queue and credits:
//  - Circular FIFO of {pc,parcel,misaligned,fault}; wr/rd pointers of log2(DEPTH)+1 bits, wrap naturally.
//  - credit = count + outst. issue_ok = !if_flush_pending && credit<DEPTH && outst<MAX_OUTST.
//  Aligned issue:
//  - imem_req = issue_ok && if_nxt_pc[1:0]==0 (combinational).
//  - Accept = imem_req && !imem_stall; on accept, if_stall_nxt_pc=0 and outst++.
//  Misaligned issue (if_nxt_pc[1:0]!=0):
//  - Issued only when issue_ok && outst==0 && discard==0.
//  - Pushes {if_nxt_pc, 0, misaligned=1, fault=0} directly; no imem_req; if_stall_nxt_pc=0.
//  - Otherwise if_stall_nxt_pc=1.
//  Response:
//  - imem_ack with discard>0: discard--, no push.
//  - Else push {pc from in-order PC tag FIFO (MAX_OUTST deep), imem_q, 0, imem_err}; outst--.
//  Output and pop:
//  - Head drives if_parcel*; if_parcel_valid = !empty && !if_flush.
//  - Pop when valid && !if_stall.
//  - Push and pop in the same cycle are both performed; full+pop+push is legal, count unchanged.
//  Flush (if_flush=1):
//  - Queue emptied next cycle.
//  - discard <= discard + outst - (ack this cycle); outst <= 0.
//  - No issue during the flush cycle (if_stall_nxt_pc=1, imem_req=0).
//  - Fetch restarts at if_nxt_pc the following cycle, subject to credits.
//  - A flush coincident with an ack drops that ack.
//  Other rules:
//  - imem_req may drop while stalled only due to flush; address held otherwise.
//  - Asserting rst mid-transaction clears all state; late acks after reset are undefined (bus reset together).
//  - Latency: issue -> if_parcel_valid = bus latency + 1 cycle (registered queue).
// TESTING
//  1. Reset, if_nxt_pc=0x200, 1-cycle ack, if_stall=0 ->
//     parcels for 0x200, 0x204, 0x208 in order, 1 per cycle after fill.
//  2. if_stall=1 held, acks stream ->
//     exactly DEPTH entries queued; imem_req=0; if_stall_nxt_pc=1 until a pop.
//  3. Two reads outstanding (0x300, 0x304), if_flush with new PC 0x400 ->
//     next 2 acks dropped; first valid parcel has if_parcel_pc=0x400.
//  4. if_nxt_pc=0x202 ->
//     no imem_req; parcel valid with misaligned=1, pc=0x202, parcel=0.
//  5. Ack with imem_err=1 for 0x500 -> head pc=0x500, page_fault=1.
//  6. imem_stall=1 for 3 cycles ->
//     imem_adr stable, if_stall_nxt_pc=1; accepted on the 4th cycle.

Source files
------------

// File: rtl/riscv_if_prefetch_if.sv
// Fetch-side handshake bundle for the instruction prefetch buffer: core fetch port plus imem read bus.
// Latency: none (wires only).
// Backpressure: carried by if_stall / if_stall_nxt_pc on the core side and imem_stall on the bus side.
interface riscv_if_prefetch_if #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32
);
  // core fetch port
  logic [XLEN-1:0]        if_nxt_pc;
  logic                   if_stall;
  logic                   if_flush;
  logic                   if_stall_nxt_pc;
  logic [PARCEL_SIZE-1:0] if_parcel;
  logic [XLEN-1:0]        if_parcel_pc;
  logic                   if_parcel_valid;
  logic                   if_parcel_misaligned;
  logic                   if_parcel_page_fault;
  // instruction memory read bus
  logic                   imem_req;
  logic [XLEN-1:0]        imem_adr;
  logic                   imem_stall;
  logic                   imem_ack;
  logic [XLEN-1:0]        imem_q;
  logic                   imem_err;

  // prefetch unit view: masters the imem bus, serves the core
  modport master (
    input  if_nxt_pc, if_stall, if_flush, imem_stall, imem_ack, imem_q, imem_err,
    output if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
           if_parcel_misaligned, if_parcel_page_fault, imem_req, imem_adr
  );

  // environment view: core and memory
  modport slave (
    output if_nxt_pc, if_stall, if_flush, imem_stall, imem_ack, imem_q, imem_err,
    input  if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
           if_parcel_misaligned, if_parcel_page_fault, imem_req, imem_adr
  );
endinterface

// File: rtl/riscv_if_prefetch.sv
// Instruction prefetch buffer: issues pipelined imem word reads and queues parcels with PC and fault flags.
// Latency: issue -> if_parcel_valid = bus latency + 1 cycle (registered queue).
// Backpressure: new fetch addresses refused (if_stall_nxt_pc) while queue entries plus reads in flight reach DEPTH.
module riscv_if_prefetch #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4,
  parameter int MAX_OUTST   = 2
) (
  input  logic                clk,
  input  logic                rst,
  riscv_if_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam int OW = $clog2(MAX_OUTST + 1);
  // discard can exceed MAX_OUTST when flushes repeat faster than the bus answers
  localparam int DW = OW + 4;
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [PARCEL_SIZE-1:0] parcel;
    logic                   misaligned;
    logic                   fault;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [XLEN-1:0] tag_mem [MAX_OUTST];

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] credit;
  logic [OW-1:0] outst;
  logic [DW-1:0] discard;
  logic [TW-1:0] tag_wr, tag_rd;

  logic   empty, issue_ok, aligned, accept, mis_issue, ack_keep, push, pop, valid;
  entry_t push_dat, head;

  // credit accounting and issue decisions
  always_comb begin
    count     = wr_ptr - rd_ptr;
    empty     = (count == '0);
    credit    = CW'(count) + CW'(outst);
    issue_ok  = !rst && !bus.if_flush && (credit < CW'(DEPTH)) && (outst < OW'(MAX_OUTST));
    aligned   = (bus.if_nxt_pc[1:0] == 2'b00);
    accept    = issue_ok && aligned && !bus.imem_stall;
    // misaligned entries bypass the bus, so wait until nothing older is still in flight
    mis_issue = issue_ok && !aligned && (outst == '0) && (discard == '0);
    ack_keep  = bus.imem_ack && !bus.if_flush && (discard == '0);
    push      = ack_keep || mis_issue;
    push_dat  = '0;
    if (ack_keep) begin
      push_dat.pc     = tag_mem[tag_rd];
      push_dat.parcel = bus.imem_q;
      push_dat.fault  = bus.imem_err;
    end else begin
      push_dat.pc         = bus.if_nxt_pc;
      push_dat.misaligned = 1'b1;
    end
    valid = !empty && !bus.if_flush;
    pop   = valid && !bus.if_stall;
    head  = empty ? '0 : q_mem[rd_ptr[AW-1:0]];
  end

  assign bus.imem_req             = issue_ok && aligned;
  assign bus.imem_adr             = (issue_ok && aligned) ? bus.if_nxt_pc : '0;
  assign bus.if_stall_nxt_pc      = !(accept || mis_issue);
  assign bus.if_parcel_valid      = valid;
  assign bus.if_parcel            = head.parcel;
  assign bus.if_parcel_pc         = head.pc;
  assign bus.if_parcel_misaligned = head.misaligned;
  assign bus.if_parcel_page_fault = head.fault;

  // queue pointers; a flush empties the queue (nothing is pushed in a flush cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.if_flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // outstanding/discard counters and the in-order PC tag pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst   <= '0;
      discard <= '0;
      tag_wr  <= '0;
      tag_rd  <= '0;
    end else if (bus.if_flush) begin
      // every read still on the bus, minus the one answered now, must be dropped
      discard <= discard + DW'(outst) - DW'(bus.imem_ack);
      outst   <= '0;
      tag_wr  <= '0;
      tag_rd  <= '0;
    end else begin
      if (bus.imem_ack && (discard != '0)) discard <= discard - 1'b1;
      outst <= outst + OW'(accept) - OW'(ack_keep);
      if (accept)   tag_wr <= (tag_wr == TW'(MAX_OUTST - 1)) ? '0 : tag_wr + 1'b1;
      if (ack_keep) tag_rd <= (tag_rd == TW'(MAX_OUTST - 1)) ? '0 : tag_rd + 1'b1;
    end
  end

  // storage arrays; contents are qualified by the pointers so they need no reset
  always_ff @(posedge clk) begin
    if (push)   q_mem[wr_ptr[AW-1:0]] <= push_dat;
    if (accept) tag_mem[tag_wr]       <= bus.if_nxt_pc;
  end
endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Self-checking bench for riscv_if_prefetch: scoreboard of accepted fetches against popped parcels.
// Latency: bus model acks in order a programmable number of cycles after acceptance.
// Backpressure: core stall and bus stall driven per test.
module tb_riscv_if_prefetch;
  localparam int XLEN = 32, DEPTH = 4, MAX_OUTST = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  riscv_if_prefetch_if #(.XLEN(XLEN), .PARCEL_SIZE(XLEN)) bus ();

  riscv_if_prefetch #(.XLEN(XLEN), .PARCEL_SIZE(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] parcel;
    logic        mis;
    logic        flt;
  } ent_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] due;
  } rd_t;

  ent_t sb[$];
  rd_t  busq[$];

  int errors = 0, checks = 0;
  int cyc = 0, lat = 1, pops = 0;
  logic        first_seen, first_mis, fault_seen, req_bad;
  logic [31:0] first_pc, first_parcel;
  logic        s_req, s_snp, s_vld;
  logic [31:0] s_adr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // one clock: sample at negedge, update model, then drive next-cycle inputs after posedge
  task automatic tick();
    logic acc;
    ent_t e;
    rd_t  r;
    @(negedge clk);
    s_req = bus.imem_req;
    s_adr = bus.imem_adr;
    s_snp = bus.if_stall_nxt_pc;
    s_vld = bus.if_parcel_valid;
    acc   = !rst && !bus.if_flush && !bus.if_stall_nxt_pc;
    if (!rst && bus.if_nxt_pc[1:0] != 2'b00 && bus.imem_req) req_bad = 1'b1;
    if (!rst && bus.if_parcel_valid && !bus.if_stall) begin
      if (sb.size() == 0) begin
        check("valid_when_empty", 32'(bus.if_parcel_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("parcel_pc", bus.if_parcel_pc, e.pc);
        check("parcel_dat", bus.if_parcel, e.parcel);
        check("parcel_mis", 32'(bus.if_parcel_misaligned), 32'(e.mis));
        check("parcel_flt", 32'(bus.if_parcel_page_fault), 32'(e.flt));
        pops++;
        if (!first_seen) begin
          first_seen   = 1'b1;
          first_pc     = bus.if_parcel_pc;
          first_mis    = bus.if_parcel_misaligned;
          first_parcel = bus.if_parcel;
        end
        if (bus.if_parcel_page_fault) fault_seen = 1'b1;
      end
    end
    if (!rst && bus.if_flush) sb.delete();
    if (acc) begin
      if (bus.if_nxt_pc[1:0] == 2'b00) begin
        sb.push_back('{pc: bus.if_nxt_pc, parcel: mdat(bus.if_nxt_pc), mis: 1'b0,
                       flt: (bus.if_nxt_pc == 32'h500)});
        busq.push_back('{adr: bus.if_nxt_pc, due: 32'(cyc + lat)});
      end else begin
        sb.push_back('{pc: bus.if_nxt_pc, parcel: 32'd0, mis: 1'b1, flt: 1'b0});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) bus.if_nxt_pc = bus.if_nxt_pc + 32'd4;
    bus.imem_ack = 1'b0;
    bus.imem_q   = '0;
    bus.imem_err = 1'b0;
    if (rst) begin
      busq.delete();
    end else if (busq.size() > 0 && busq[0].due <= 32'(cyc)) begin
      r = busq.pop_front();
      bus.imem_ack = 1'b1;
      bus.imem_q   = mdat(r.adr);
      bus.imem_err = (r.adr == 32'h500);
    end
  endtask

  task automatic flush_to(input logic [31:0] pc);
    bus.if_nxt_pc = pc;
    bus.if_flush  = 1'b1;
    tick();
    bus.if_flush  = 1'b0;
    first_seen    = 1'b0;
  endtask

  initial begin
    bus.if_nxt_pc  = 32'h200;
    bus.if_stall   = 1'b0;
    bus.if_flush   = 1'b0;
    bus.imem_stall = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_q     = '0;
    bus.imem_err   = 1'b0;
    first_seen = 1'b0; first_mis = 1'b0; fault_seen = 1'b0; req_bad = 1'b0;
    first_pc = '0; first_parcel = '0;
    #2 rst = 1'b1;

    // reset state
    tick();
    check("rst_valid", 32'(s_vld), 32'd0);
    check("rst_stall_nxt", 32'(s_snp), 32'd1);
    check("rst_req", 32'(s_req), 32'd0);
    check("rst_adr", s_adr, 32'd0);
    check("rst_parcel", bus.if_parcel, 32'd0);
    check("rst_parcel_pc", bus.if_parcel_pc, 32'd0);
    tick();
    rst = 1'b0;

    // T1: streaming from 0x200 with 1-cycle acks, one parcel per cycle after fill
    pops = 0;
    repeat (12) tick();
    check("t1_first_pc", first_pc, 32'h200);
    check("t1_pops", 32'(pops), 32'd10);

    // T2: core stalls; queue fills to DEPTH and fetch stops until a pop
    bus.if_stall = 1'b1;
    repeat (20) tick();
    check("t2_queued", 32'(sb.size()), 32'(DEPTH));
    check("t2_req", 32'(s_req), 32'd0);
    check("t2_stall_nxt", 32'(s_snp), 32'd1);
    bus.if_stall = 1'b0;
    tick();
    check("t2_pop_cycle_stall_nxt", 32'(s_snp), 32'd1);
    tick();
    check("t2_after_pop_stall_nxt", 32'(s_snp), 32'd0);

    // T3: two reads in flight, flush to 0x400 drops both acks
    lat = 3;
    flush_to(32'h300);
    tick();
    check("t3_acc_300", s_adr, 32'h300);
    tick();
    check("t3_acc_304", s_adr, 32'h304);
    tick();
    check("t3_full_outst", 32'(s_snp), 32'd1);
    flush_to(32'h400);
    check("t3_flush_req", 32'(s_req), 32'd0);
    check("t3_flush_stall_nxt", 32'(s_snp), 32'd1);
    for (int i = 0; i < 30 && !first_seen; i++) tick();
    check("t3_seen", 32'(first_seen), 32'd1);
    check("t3_first_pc", first_pc, 32'h400);

    // T4: misaligned PC produces a flagged parcel without a bus request
    lat = 1;
    req_bad = 1'b0;
    flush_to(32'h202);
    for (int i = 0; i < 30 && !first_seen; i++) tick();
    check("t4_seen", 32'(first_seen), 32'd1);
    check("t4_no_req", 32'(req_bad), 32'd0);
    check("t4_first_pc", first_pc, 32'h202);
    check("t4_first_mis", 32'(first_mis), 32'd1);
    check("t4_first_parcel", first_parcel, 32'd0);

    // T5: bus error on 0x500 reported as page fault
    lat = 2;
    fault_seen = 1'b0;
    flush_to(32'h4f8);
    for (int i = 0; i < 30 && !fault_seen; i++) tick();
    check("t5_fault", 32'(fault_seen), 32'd1);

    // T6: bus stall holds the request and address for 3 cycles
    bus.imem_stall = 1'b1;
    flush_to(32'h600);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_req", 32'(s_req), 32'd1);
      check("t6_adr", s_adr, 32'h600);
      check("t6_stall_nxt", 32'(s_snp), 32'd1);
    end
    bus.imem_stall = 1'b0;
    tick();
    check("t6_accept", 32'(s_snp), 32'd0);
    check("t6_accept_adr", s_adr, 32'h600);

    // random core stalls with streaming reads
    for (int i = 0; i < 60; i++) begin
      bus.if_stall = ($urandom_range(0, 2) == 0);
      tick();
    end
    bus.if_stall = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
